// File: rtl/fifo_pkg.sv
// Shared read/write-side FIFO constants: default data and counter widths, fixed read latency.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int READ_LATENCY   = 1;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; dout is always the oldest entry.
// Latency: push visible on dout the cycle after; push and pop may coincide.
// Backpressure: caller must not push when full without a same-cycle pop.
module skid_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;

    assign dout = ent0;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves; incoming word goes behind whatever remains.
                    if (occ == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end else begin
                        ent0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_read_drainer.sv
// Pops the FIFO read port and re-presents words as a framed valid/ready stream.
// Latency: 2 cycles from pop to m_valid; sustains 1 word/cycle unstalled.
// Backpressure: pops only when the 2-entry buffer has room, so at most 2 words leave the FIFO while stalled.
module fifo_read_drainer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  pkt_count
);
    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    logic [1:0]              occ;
    logic [READ_LATENCY-1:0] inflight;
    logic [2:0]              committed;
    logic                    pop;
    logic [7:0]              beat_idx;

    assign pop       = m_valid & m_ready;
    assign committed = {1'b0, occ} + 3'(inflight);
    // A slot freed by this cycle's pop may be refilled by a read issued in the same cycle.
    assign fifo_r_en = enable & ~fifo_empty & ~rrst &
                       ((committed < 3'd2) | ((committed == 3'd2) & pop));
    assign m_valid   = (occ != 2'd0);
    assign m_last    = m_valid & (beat_idx == LAST_IDX);

    skid_buf2 #(
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk  (rclk),
        .rst  (rrst),
        .push (inflight[0]),
        .din  (fifo_r_data),
        .pop  (pop),
        .dout (m_data),
        .occ  (occ)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight   <= '0;
            beat_idx   <= 8'd0;
            word_count <= '0;
            pkt_count  <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (pop) begin
                word_count <= word_count + 1'b1;
                if (beat_idx == LAST_IDX) begin
                    beat_idx  <= 8'd0;
                    pkt_count <= pkt_count + 1'b1;
                end else begin
                    beat_idx <= beat_idx + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_drainer.sv
// Directed bench for fifo_read_drainer against a behavioural 1-cycle-latency FIFO model.
module tb_fifo_read_drainer;
    logic        rclk = 1'b0;
    logic        rrst;
    logic        enable;
    logic        fifo_empty = 1'b1;
    logic        fifo_r_en;
    logic [7:0]  fifo_r_data = 8'h00;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] word_count;
    logic [15:0] pkt_count;

    logic        fifo_flush;
    logic [7:0]  q[$];
    logic [7:0]  wq[$];
    logic [7:0]  rd_tmp;
    logic [8:0]  got[$];
    int          pop_cnt = 0;
    int          bad_pop = 0;
    int          checks  = 0;
    int          errors  = 0;
    int          p0;

    fifo_read_drainer #(
        .DATA_WIDTH (8),
        .PKT_LEN    (4),
        .CNT_WIDTH  (16)
    ) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_r_en   (fifo_r_en),
        .fifo_r_data (fifo_r_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .word_count  (word_count),
        .pkt_count   (pkt_count)
    );

    always #5 rclk = ~rclk;

    // FIFO model: data appears the cycle after a pop; writes become visible one edge later.
    always @(posedge rclk) begin
        if (fifo_r_en) begin
            pop_cnt++;
            if (fifo_empty) bad_pop++;
            if (q.size() != 0) begin
                rd_tmp = q.pop_front();
                fifo_r_data <= rd_tmp;
            end
        end
        if (fifo_flush) begin
            q.delete();
            wq.delete();
        end
        while (wq.size() != 0) q.push_back(wq.pop_front());
        fifo_empty <= (q.size() == 0);
    end

    always @(negedge rclk) begin
        if (!rrst && m_valid && m_ready) got.push_back({m_last, m_data});
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rrst       = 1'b1;
        enable     = 1'b1;
        m_ready    = 1'b1;
        fifo_flush = 1'b0;

        // Reset with FIFO preloaded
        for (int i = 1; i <= 8; i++) wq.push_back(8'(i));
        tick();
        for (int c = 0; c < 3; c++) begin
            check("rst_r_en", fifo_r_en, 0);
            check("rst_valid", m_valid, 0);
            check("rst_last", m_last, 0);
            check("rst_data", m_data, 0);
            check("rst_wcnt", word_count, 0);
            check("rst_pcnt", pkt_count, 0);
            tick();
        end

        // Streaming 0x01..0x08
        rrst = 1'b0;
        tick();
        check("stream_latency", m_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_valid", m_valid, 1);
            check("stream_data", m_data, 32'(i + 1));
            check("stream_last", m_last, 32'(i % 4 == 3));
        end
        tick();
        check("stream_idle", m_valid, 0);
        check("stream_wcnt", word_count, 8);
        check("stream_pcnt", pkt_count, 2);
        check("stream_pops", pop_cnt, 8);

        // Backpressure
        m_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 1; i <= 8; i++) wq.push_back(8'(i));
        repeat (10) tick();
        check("bp_pops", pop_cnt - p0, 2);
        check("bp_valid", m_valid, 1);
        check("bp_data_held", m_data, 8'h01);
        check("bp_no_r_en", fifo_r_en, 0);
        got.delete();
        m_ready = 1'b1;
        #1;
        check("bp_resume", fifo_r_en, 1);
        repeat (14) tick();
        check("bp_count", got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (got.size() > i) check("bp_beat", got[i], {(i % 4 == 3), 8'(i + 1)});
        check("bp_wcnt", word_count, 16);
        check("bp_pcnt", pkt_count, 4);
        check("bp_pops_total", pop_cnt - p0, 8);

        // Empty boundary: one word at a time
        got.delete();
        p0 = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            wq.push_back(8'(8'h11 + k));
            repeat (6) tick();
            check("empty_pops", pop_cnt - p0, 32'(k + 1));
            check("empty_idle", m_valid, 0);
        end
        check("empty_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (got.size() > i) check("empty_beat", got[i], {(i == 3), 8'(8'h11 + i)});
        check("empty_bad_pop", bad_pop, 0);

        // Enable drop after the second beat's pop; in-flight word still drains
        got.delete();
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) wq.push_back(8'(8'h21 + i));
        repeat (3) tick();
        enable = 1'b0;
        repeat (6) tick();
        check("en_pops", pop_cnt - p0, 2);
        check("en_drained", m_valid, 0);
        check("en_count", got.size(), 2);
        if (got.size() > 1) begin
            check("en_beat1", got[0], {1'b0, 8'h21});
            check("en_beat2", got[1], {1'b0, 8'h22});
        end
        enable = 1'b1;
        repeat (8) tick();
        check("en_resume_count", got.size(), 4);
        if (got.size() > 3) begin
            check("en_beat3", got[2], {1'b0, 8'h23});
            check("en_beat4", got[3], {1'b1, 8'h24});
        end
        check("en_wcnt", word_count, 24);
        check("en_pcnt", pkt_count, 6);

        // Mid-run reset with two words buffered
        got.delete();
        m_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) wq.push_back(8'(8'h31 + i));
        repeat (6) tick();
        check("mrst_pops", pop_cnt - p0, 2);
        check("mrst_full", m_valid, 1);
        check("mrst_head", m_data, 8'h31);
        rrst = 1'b1;
        fifo_flush = 1'b1;
        tick();
        check("mrst_valid", m_valid, 0);
        check("mrst_data", m_data, 0);
        check("mrst_wcnt", word_count, 0);
        check("mrst_pcnt", pkt_count, 0);
        rrst = 1'b0;
        fifo_flush = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) wq.push_back(8'(8'hA0 + i));
        repeat (8) tick();
        check("mrst_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (got.size() > i) check("mrst_beat", got[i], {(i == 3), 8'(8'hA0 + i)});
        check("mrst_wcnt2", word_count, 4);
        check("mrst_pcnt2", pkt_count, 1);

        // Random enable / m_ready, then full-rate drain
        got.delete();
        for (int i = 0; i < 40; i++) wq.push_back(8'(8'h40 + i));
        repeat (300) begin
            enable  = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (40) tick();
        check("rand_count", got.size(), 40);
        for (int i = 0; i < 40; i++)
            if (got.size() > i) check("rand_beat", got[i], {(i % 4 == 3), 8'(8'h40 + i)});
        check("rand_wcnt", word_count, 44);
        check("rand_pcnt", pkt_count, 11);
        check("rand_bad_pop", bad_pop, 0);
        check("rand_idle", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
